// File: rtl/mini68k_bus_resp_pkg.sv
// Shared mini68k bus definitions: responder state encoding and wait-state counter width.
// Bus masters and responders import this package so that both sides agree on these definitions.
package mini68k_bus_resp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_ACK     = 3'd4
    } bus_state_t;

    // Wide enough for the largest wait-state setting (15).
    localparam int WAIT_W = 4;

endpackage

// File: rtl/mini68k_addr_decode.sv
// Address window compare for mini68k bus responders.
// Only the bits above the window size take part in the match.
module mini68k_addr_decode #(
    parameter logic [23:0] BASE_ADDR = 24'h000000,
    parameter int          SIZE_LOG2 = 16
) (
    input  logic [23:0] addr,
    output logic        hit
);

    localparam logic [23:0] TAG_MASK = ~((24'd1 << SIZE_LOG2) - 24'd1);

    assign hit = ((addr ^ BASE_ADDR) & TAG_MASK) == 24'd0;

endmodule

// File: rtl/mini68k_bus_resp.sv
// mini68k bus responder: decodes an address window and turns each bus cycle
// into single-cycle memory read/write strobes, then acknowledges the bus cycle with dtack_n.
module mini68k_bus_resp
    import mini68k_bus_resp_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR   = 24'h000000,
    parameter int          SIZE_LOG2   = 16,
    parameter int          WAIT_STATES = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [23:0]          addr,
    inout  wire  [15:0]          data,
    input  logic                 as_n,
    input  logic                 rw,
    input  logic                 uds_n,
    input  logic                 lds_n,
    output logic                 dtack_n,
    output logic [SIZE_LOG2-2:0] mem_addr,
    output logic [15:0]          mem_wdata,
    output logic [1:0]           mem_be,
    output logic                 mem_we,
    output logic                 mem_re,
    input  logic [15:0]          mem_rdata,
    output logic                 busy
);

    bus_state_t           state, state_d;
    logic [WAIT_W-1:0]    cnt, cnt_d;
    logic [SIZE_LOG2-2:0] addr_q;
    logic                 rw_q;
    logic [1:0]           be_q;
    logic [15:0]          wdata_q;
    logic [15:0]          rdata_q;
    logic                 oe_q;
    logic                 oe_d;
    logic                 dtack_d;
    logic                 hit;
    logic                 latch_en;
    logic                 capture_en;

    mini68k_addr_decode #(
        .BASE_ADDR (BASE_ADDR),
        .SIZE_LOG2 (SIZE_LOG2)
    ) u_decode (
        .addr (addr),
        .hit  (hit)
    );

    // dtack_n and the data driver are registered so they can only change on clock edges.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        dtack_d    = dtack_n;
        oe_d       = oe_q;
        latch_en   = 1'b0;
        capture_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!as_n && hit) begin
                    latch_en = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_ACCESS;
                    end else begin
                        cnt_d   = WAIT_W'(WAIT_STATES);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (as_n) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt - WAIT_W'(1);
                    if (cnt == WAIT_W'(1)) begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (rw_q) begin
                    state_d = ST_CAPTURE;
                end else begin
                    dtack_d = 1'b0;
                    state_d = ST_ACK;
                end
            end
            ST_CAPTURE: begin
                if (as_n) begin
                    state_d = ST_IDLE;
                end else begin
                    capture_en = 1'b1;
                    oe_d       = 1'b1;
                    dtack_d    = 1'b0;
                    state_d    = ST_ACK;
                end
            end
            ST_ACK: begin
                if (as_n) begin
                    dtack_d = 1'b1;
                    oe_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                dtack_d = 1'b1;
                oe_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            dtack_n <= 1'b1;
            oe_q    <= 1'b0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            be_q    <= 2'b00;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            dtack_n <= dtack_d;
            oe_q    <= oe_d;
            if (latch_en) begin
                addr_q  <= addr[SIZE_LOG2-1:1];
                rw_q    <= rw;
                be_q    <= {~uds_n, ~lds_n};
                wdata_q <= data;
            end
            if (capture_en) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    // A write with neither byte strobe active still completes on the bus but never touches memory.
    assign mem_re    = (state == ST_ACCESS) && rw_q;
    assign mem_we    = (state == ST_ACCESS) && !rw_q && (be_q != 2'b00);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign busy      = (state != ST_IDLE);

    assign data = oe_q ? rdata_q : 16'bz;

endmodule

// File: tb/tb_mini68k_bus_resp.sv
// Directed bench for mini68k_bus_resp: one zero-wait responder with a small memory
// and one three-wait responder used for byte-write and abort timing.
module tb_mini68k_bus_resp;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [23:0] addr  = 24'h0;
    logic        rw    = 1'b1;
    logic        uds_n = 1'b1;
    logic        lds_n = 1'b1;
    logic        as0_n = 1'b1;
    logic        as1_n = 1'b1;
    logic        drv0  = 1'b0;
    logic        drv1  = 1'b0;
    logic [15:0] drv_val = 16'h0;

    // Pulled-up buses: a released responder reads back as all ones.
    tri1 [15:0] data0;
    tri1 [15:0] data1;
    assign data0 = drv0 ? drv_val : 16'bz;
    assign data1 = drv1 ? drv_val : 16'bz;

    logic        dtack0_n, dtack1_n;
    logic [14:0] mem_addr0, mem_addr1;
    logic [15:0] mem_wdata0, mem_wdata1;
    logic [1:0]  mem_be0, mem_be1;
    logic        mem_we0, mem_we1, mem_re0, mem_re1;
    logic        busy0, busy1;
    logic [15:0] mem_rdata0;
    logic [15:0] mem_rdata1;
    logic [15:0] mem0 [0:15];

    int total   = 0;
    int passed  = 0;
    int we1_cnt = 0;

    assign mem_rdata1 = 16'hC0DE;

    mini68k_bus_resp dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (addr),
        .data      (data0),
        .as_n      (as0_n),
        .rw        (rw),
        .uds_n     (uds_n),
        .lds_n     (lds_n),
        .dtack_n   (dtack0_n),
        .mem_addr  (mem_addr0),
        .mem_wdata (mem_wdata0),
        .mem_be    (mem_be0),
        .mem_we    (mem_we0),
        .mem_re    (mem_re0),
        .mem_rdata (mem_rdata0),
        .busy      (busy0)
    );

    mini68k_bus_resp #(.WAIT_STATES(3)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (addr),
        .data      (data1),
        .as_n      (as1_n),
        .rw        (rw),
        .uds_n     (uds_n),
        .lds_n     (lds_n),
        .dtack_n   (dtack1_n),
        .mem_addr  (mem_addr1),
        .mem_wdata (mem_wdata1),
        .mem_be    (mem_be1),
        .mem_we    (mem_we1),
        .mem_re    (mem_re1),
        .mem_rdata (mem_rdata1),
        .busy      (busy1)
    );

    always #5 clk = ~clk;

    // Memory model: read data appears the cycle after mem_re; writes honour byte enables.
    always @(posedge clk) begin
        if (mem_re0) mem_rdata0 <= mem0[mem_addr0[3:0]];
        if (mem_we0) begin
            if (mem_be0[1]) mem0[mem_addr0[3:0]][15:8] <= mem_wdata0[15:8];
            if (mem_be0[0]) mem0[mem_addr0[3:0]][7:0]  <= mem_wdata0[7:0];
        end
        if (mem_we1) we1_cnt <= we1_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input bit sel, input logic [23:0] a, input logic r,
                                 input logic u, input logic l, input logic [15:0] wd);
        addr    = a;
        rw      = r;
        uds_n   = u;
        lds_n   = l;
        drv_val = wd;
        if (sel) begin
            drv1  = !r;
            as1_n = 1'b0;
        end else begin
            drv0  = !r;
            as0_n = 1'b0;
        end
    endtask

    task automatic endCycle();
        as0_n = 1'b1;
        as1_n = 1'b1;
        drv0  = 1'b0;
        drv1  = 1'b0;
    endtask

    task automatic write0(input logic [23:0] a, input logic u, input logic l, input logic [15:0] wd);
        applyStimulus(0, a, 1'b0, u, l, wd);
        tick(1);
        checkOutput("wr_we", mem_we0, {u, l} != 2'b11);
        checkOutput("wr_addr", mem_addr0, a[15:1]);
        checkOutput("wr_be", mem_be0, {~u, ~l});
        checkOutput("wr_wdata", mem_wdata0, wd);
        checkOutput("wr_dtack_early", dtack0_n, 1'b1);
        tick(1);
        checkOutput("wr_dtack", dtack0_n, 1'b0);
        checkOutput("wr_we_once", mem_we0, 1'b0);
        endCycle();
        tick(1);
        checkOutput("wr_release", dtack0_n, 1'b1);
    endtask

    task automatic read0(input logic [23:0] a, input logic [15:0] exp);
        applyStimulus(0, a, 1'b1, 1'b0, 1'b0, 16'h0);
        tick(1);
        checkOutput("rd_re", mem_re0, 1'b1);
        checkOutput("rd_addr", mem_addr0, a[15:1]);
        checkOutput("rd_dtack_stale", dtack0_n, 1'b1);
        tick(1);
        checkOutput("rd_re_once", mem_re0, 1'b0);
        checkOutput("rd_dtack_early", dtack0_n, 1'b1);
        tick(1);
        checkOutput("rd_dtack", dtack0_n, 1'b0);
        checkOutput("rd_data", data0, exp);
        endCycle();
        tick(1);
        checkOutput("rd_release_dtack", dtack0_n, 1'b1);
        checkOutput("rd_release_data", data0, 16'hFFFF);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        tick(2);
        checkOutput("rst_dtack0", dtack0_n, 1'b1);
        checkOutput("rst_dtack1", dtack1_n, 1'b1);
        checkOutput("rst_busy0", busy0, 1'b0);
        checkOutput("rst_data0", data0, 16'hFFFF);
        checkOutput("rst_we0", mem_we0, 1'b0);
        checkOutput("rst_re0", mem_re0, 1'b0);
        checkOutput("rst_addr0", mem_addr0, 15'h0);
        rst_n = 1'b1;
        tick(1);

        write0(24'h000010, 1'b0, 1'b0, 16'hBEEF);
        read0(24'h000010, 16'hBEEF);

        // Outside the default 64 KiB window: nothing may respond.
        applyStimulus(0, 24'h010000, 1'b1, 1'b0, 1'b0, 16'h0);
        tick(4);
        checkOutput("oow_dtack", dtack0_n, 1'b1);
        checkOutput("oow_busy", busy0, 1'b0);
        checkOutput("oow_data", data0, 16'hFFFF);
        checkOutput("oow_re", mem_re0, 1'b0);
        checkOutput("oow_addr_kept", mem_addr0, 15'h0008);
        endCycle();
        tick(1);

        applyStimulus(1, 24'h000022, 1'b0, 1'b1, 1'b0, 16'h12AB);
        tick(3);
        checkOutput("bw_wait_dtack", dtack1_n, 1'b1);
        checkOutput("bw_wait_we", mem_we1, 1'b0);
        checkOutput("bw_wait_busy", busy1, 1'b1);
        tick(1);
        checkOutput("bw_we", mem_we1, 1'b1);
        checkOutput("bw_be", mem_be1, 2'b01);
        checkOutput("bw_wdata", mem_wdata1, 16'h12AB);
        checkOutput("bw_addr", mem_addr1, 15'h0011);
        checkOutput("bw_dtack_early", dtack1_n, 1'b1);
        tick(1);
        checkOutput("bw_dtack", dtack1_n, 1'b0);
        endCycle();
        tick(1);
        checkOutput("bw_release", dtack1_n, 1'b1);
        checkOutput("bw_idle", busy1, 1'b0);

        applyStimulus(1, 24'h000024, 1'b0, 1'b0, 1'b0, 16'h7777);
        tick(2);
        endCycle();
        tick(1);
        checkOutput("abort_idle", busy1, 1'b0);
        tick(4);
        checkOutput("abort_dtack", dtack1_n, 1'b1);
        checkOutput("abort_no_we", we1_cnt, 1);

        write0(24'h000004, 1'b0, 1'b0, 16'h1234);
        read0(24'h000004, 16'h1234);
        write0(24'h000006, 1'b0, 1'b0, 16'hAAAA);
        write0(24'h000006, 1'b0, 1'b1, 16'h5678);
        read0(24'h000006, 16'h56AA);
        write0(24'h000007, 1'b1, 1'b1, 16'h0000);
        read0(24'h000006, 16'h56AA);

        applyStimulus(0, 24'h000010, 1'b1, 1'b0, 1'b0, 16'h0);
        tick(3);
        checkOutput("rst_ack_dtack_before", dtack0_n, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_ack_dtack", dtack0_n, 1'b1);
        checkOutput("rst_ack_data", data0, 16'hFFFF);
        checkOutput("rst_ack_busy", busy0, 1'b0);
        endCycle();
        tick(1);
        rst_n = 1'b1;
        tick(1);
        read0(24'h000010, 16'hBEEF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
